// File: rtl/keccak_absorb_ctrl.sv
// rtl/keccak_absorb_ctrl.sv - SHA3 sponge absorb sequencer: lane XOR-in, byte-accurate padding, permutation control
module keccak_absorb_ctrl #(
    parameter int          DATA_WIDTH = 64,
    parameter int          KEEP_WIDTH = 8,
    parameter logic [7:0]  PAD_DOMAIN = 8'h06
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic [1:0]            s_tuser,
    output logic                  state_clr,
    output logic                  lane_we,
    output logic [4:0]            lane_idx,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic                  perm_start,
    input  logic                  perm_done,
    output logic                  busy,
    output logic                  digest_valid,
    input  logic                  digest_ready,
    output logic [1:0]            digest_mode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_PERM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        pad_ins_q, pad_ins_d;
    logic        msg_end_q, msg_end_d;

    logic [4:0]            rate_last;
    logic [3:0]            nbytes;
    logic [DATA_WIDTH-1:0] tail_lane;
    logic                  at_last;

    always_comb begin
        case (mode_q)
            2'd0:    rate_last = 5'd17;
            2'd1:    rate_last = 5'd16;
            2'd2:    rate_last = 5'd12;
            default: rate_last = 5'd8;
        endcase
    end

    assign at_last = (cnt_q == rate_last);

    // tkeep is contiguous from the LSB, so its popcount is the count of message bytes
    always_comb begin
        nbytes = 4'd0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            nbytes = nbytes + 4'(s_tkeep[k]);
        end
    end

    always_comb begin
        tail_lane = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (4'(k) < nbytes) begin
                tail_lane[8*k +: 8] = s_tdata[8*k +: 8];
            end else if (4'(k) == nbytes) begin
                tail_lane[8*k +: 8] = PAD_DOMAIN;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            mode_q    <= 2'd0;
            pad_ins_q <= 1'b0;
            msg_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pad_ins_q <= pad_ins_d;
            msg_end_q <= msg_end_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        pad_ins_d    = pad_ins_q;
        msg_end_d    = msg_end_q;
        s_tready     = 1'b0;
        state_clr    = 1'b0;
        lane_we      = 1'b0;
        lane_idx     = 5'd0;
        lane_data    = '0;
        perm_start   = 1'b0;
        digest_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_tvalid) begin
                    state_clr = 1'b1;
                    mode_d    = s_tuser;
                    cnt_d     = 5'd0;
                    pad_ins_d = 1'b0;
                    msg_end_d = 1'b0;
                    state_d   = S_ABSORB;
                end
            end

            S_ABSORB: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    lane_we  = 1'b1;
                    lane_idx = cnt_q;
                    if (!s_tlast || nbytes == 4'd8) begin
                        lane_data = s_tdata;
                        msg_end_d = s_tlast;
                        if (at_last) begin
                            state_d = S_PERM;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                            if (s_tlast) begin
                                state_d = S_PAD;
                            end
                        end
                    end else begin
                        lane_data = tail_lane;
                        pad_ins_d = 1'b1;
                        msg_end_d = 1'b1;
                        if (at_last) begin
                            lane_data[DATA_WIDTH-1 -: 8] = tail_lane[DATA_WIDTH-1 -: 8] | 8'h80;
                            state_d = S_PERM;
                        end else begin
                            cnt_d   = cnt_q + 5'd1;
                            state_d = S_PAD;
                        end
                    end
                end
            end

            S_PAD: begin
                lane_we  = 1'b1;
                lane_idx = cnt_q;
                // The domain byte goes into the first padding lane only if the tail beat had no room for it
                if (!pad_ins_q) begin
                    lane_data[7:0] = PAD_DOMAIN;
                    pad_ins_d      = 1'b1;
                end
                if (at_last) begin
                    lane_data[DATA_WIDTH-1 -: 8] = lane_data[DATA_WIDTH-1 -: 8] | 8'h80;
                    state_d = S_PERM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_PERM: begin
                perm_start = 1'b1;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (perm_done) begin
                    cnt_d = 5'd0;
                    if (msg_end_q && pad_ins_q) begin
                        state_d = S_DONE;
                    end else if (msg_end_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end

            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign digest_mode = mode_q;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// tb/tb_keccak_absorb_ctrl.sv - table-driven self-checking bench for keccak_absorb_ctrl
module tb_keccak_absorb_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic [1:0]  s_tuser = '0;
    logic        state_clr;
    logic        lane_we;
    logic [4:0]  lane_idx;
    logic [63:0] lane_data;
    logic        perm_start;
    logic        perm_done = 1'b0;
    logic        busy;
    logic        digest_valid;
    logic        digest_ready = 1'b0;
    logic [1:0]  digest_mode;

    keccak_absorb_ctrl #(
        .DATA_WIDTH(64),
        .KEEP_WIDTH(8),
        .PAD_DOMAIN(8'h06)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata(s_tdata),
        .s_tkeep(s_tkeep),
        .s_tlast(s_tlast),
        .s_tuser(s_tuser),
        .state_clr(state_clr),
        .lane_we(lane_we),
        .lane_idx(lane_idx),
        .lane_data(lane_data),
        .perm_start(perm_start),
        .perm_done(perm_done),
        .busy(busy),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .digest_mode(digest_mode)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  mode;
        int          nbeats;
        logic [7:0]  keep;
        int          delay;
        int          exp_wr;
        int          exp_perm;
        int          i0;
        logic [63:0] v0;
        int          i1;
        logic [63:0] v1;
        int          i2;
        logic [63:0] v2;
    } msg_t;

    msg_t tbl [7];

    int checks = 0;
    int errors = 0;

    logic [63:0] lanes [32];
    int          wr_cnt, perm_cnt, clr_cnt, rdy_in_wait, first_idx, max_idx;
    logic        any_wr, in_wait;
    int          perm_delay = 1;

    initial begin
        in_wait = 1'b0;
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge ACLK) begin
        if (lane_we) begin
            lanes[lane_idx] = lane_data;
            wr_cnt++;
            if (!any_wr) first_idx = int'(lane_idx);
            any_wr = 1'b1;
            if (int'(lane_idx) > max_idx) max_idx = int'(lane_idx);
        end
        if (perm_start) begin
            perm_cnt++;
            in_wait = 1'b1;
        end
        if (state_clr) clr_cnt++;
        if (in_wait && s_tready) rdy_in_wait++;
        if (perm_done) in_wait = 1'b0;
    end

    // Round-engine stand-in: one perm_done pulse perm_delay cycles after each perm_start
    always begin
        @(negedge ACLK);
        if (perm_start) begin
            repeat (perm_delay) @(posedge ACLK);
            #1 perm_done = 1'b1;
            @(posedge ACLK);
            #1 perm_done = 1'b0;
        end
    end

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'd0:    return 18;
            2'd1:    return 17;
            2'd2:    return 13;
            default: return 9;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic clear_capture();
        for (int i = 0; i < 32; i++) lanes[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        wr_cnt = 0; perm_cnt = 0; clr_cnt = 0; rdy_in_wait = 0;
        first_idx = -1; max_idx = -1; any_wr = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic [1:0] u);
        logic got;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge ACLK);
            if (s_tready) got = 1'b1;
            @(posedge ACLK);
            #1;
        end
        if (!got) chk("beat_accept_timeout", 64'(got), 64'd1);
    endtask

    function automatic logic [63:0] beat_data(input int i);
        return 64'hF0E1_D2C3_B4A5_9600 | 64'(i);
    endfunction

    task automatic run_msg(input int id, input msg_t m, input int hold);
        logic got;
        int   viol;
        clear_capture();
        perm_delay = m.delay;
        for (int i = 0; i < m.nbeats; i++) begin
            // tuser differs after the first beat and tkeep is junk on non-last beats: both must be ignored
            send_beat(beat_data(i), (i == m.nbeats - 1) ? m.keep : 8'h0F,
                      (i == m.nbeats - 1), (i == 0) ? m.mode : ~m.mode);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge ACLK);
            if (digest_valid) got = 1'b1;
        end
        chk($sformatf("m%0d_digest_seen", id), 64'(got), 64'd1);
        if (got) begin
            chk($sformatf("m%0d_digest_mode", id), 64'(digest_mode), 64'(m.mode));
            chk($sformatf("m%0d_perms_before_digest", id), 64'(perm_cnt), 64'(m.exp_perm));
            viol = 0;
            if (hold > 0) begin
                s_tvalid = 1'b1;
                repeat (hold) begin
                    @(posedge ACLK);
                    #1;
                    if (!digest_valid || s_tready || state_clr) viol++;
                end
                s_tvalid = 1'b0;
                chk($sformatf("m%0d_done_hold_viol", id), 64'(viol), 64'd0);
            end
            digest_ready = 1'b1;
            @(posedge ACLK);
            #1 digest_ready = 1'b0;
            chk($sformatf("m%0d_busy_after_ack", id), 64'(busy), 64'd0);
        end
        chk($sformatf("m%0d_writes", id), 64'(wr_cnt), 64'(m.exp_wr));
        chk($sformatf("m%0d_perms", id), 64'(perm_cnt), 64'(m.exp_perm));
        chk($sformatf("m%0d_clr", id), 64'(clr_cnt), 64'd1);
        chk($sformatf("m%0d_first_idx", id), 64'(first_idx), 64'd0);
        chk($sformatf("m%0d_idx_below_rate", id), 64'(max_idx < rate_of(m.mode)), 64'd1);
        chk($sformatf("m%0d_tready_in_wait", id), 64'(rdy_in_wait), 64'd0);
        chk($sformatf("m%0d_lane%0d", id, m.i0), lanes[m.i0], m.v0);
        chk($sformatf("m%0d_lane%0d", id, m.i1), lanes[m.i1], m.v1);
        chk($sformatf("m%0d_lane%0d", id, m.i2), lanes[m.i2], m.v2);
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string nm);
        @(negedge ACLK);
        chk({nm, "_lane_data"}, lane_data, 64'd0);
        chk({nm, "_ctrl"}, 64'({s_tready, state_clr, lane_we, lane_idx, perm_start,
                                busy, digest_valid, digest_mode}), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge ACLK);
        #1 ARESETn = 1'b0;
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
    endtask

    initial begin
        tbl[0] = '{2'd1, 1,  8'h00, 1,  17, 1, 0, 64'h06, 16, 64'h8000_0000_0000_0000, 5, 64'h0};
        tbl[1] = '{2'd3, 9,  8'hFF, 1,  18, 2, 0, 64'h06, 8, 64'h8000_0000_0000_0000, 3, 64'h0};
        tbl[2] = '{2'd0, 18, 8'h7F, 1,  18, 1, 17, 64'h86E1_D2C3_B4A5_9611,
                   5, 64'hF0E1_D2C3_B4A5_9605, 0, 64'hF0E1_D2C3_B4A5_9600};
        tbl[3] = '{2'd2, 20, 8'hFF, 30, 26, 2, 6, 64'hF0E1_D2C3_B4A5_9613,
                   7, 64'h06, 12, 64'h8000_0000_0000_0000};
        tbl[4] = '{2'd1, 3,  8'h07, 2,  17, 1, 2, 64'h0000_0000_06A5_9602,
                   16, 64'h8000_0000_0000_0000, 1, 64'hF0E1_D2C3_B4A5_9601};
        tbl[5] = '{2'd3, 9,  8'h3F, 1,  9,  1, 8, 64'h8006_D2C3_B4A5_9608,
                   7, 64'hF0E1_D2C3_B4A5_9607, 0, 64'hF0E1_D2C3_B4A5_9600};
        tbl[6] = '{2'd0, 18, 8'hFF, 3,  36, 2, 0, 64'h06, 17, 64'h8000_0000_0000_0000, 16, 64'h0};

        clear_capture();
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        check_idle_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            run_msg(i, tbl[i], (i == 2) ? 10 : 0);
        end

        // Reset while waiting on the permutation of a mid-message block
        clear_capture();
        perm_delay = 30;
        for (int i = 0; i < 9; i++) send_beat(beat_data(i), 8'hFF, 1'b0, 2'd3);
        s_tvalid = 1'b0;
        repeat (5) @(posedge ACLK);
        #1;
        chk("wait_busy", 64'({busy, s_tready, perm_cnt[0]}), 64'b101);
        pulse_reset();
        check_idle_outputs("rst_in_wait");
        repeat (40) @(posedge ACLK);
        #1;
        run_msg(10, tbl[0], 0);

        // Reset in the middle of a padding block
        clear_capture();
        perm_delay = 1;
        send_beat(beat_data(0), 8'hFF, 1'b1, 2'd0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("pad_lane_we", 64'({busy, lane_we}), 64'b11);
        pulse_reset();
        check_idle_outputs("rst_in_pad");
        run_msg(11, tbl[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
